// File: rtl/inner_fn_arbiter_if.sv
// Request/response and pipeline-issue bundle for inner_fn_arbiter.
// master = front-end/pipeline side, slave = arbiter side.
interface inner_fn_arbiter_if;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        pipe_start;
  logic [31:0] pipe_dataa;
  logic [31:0] pipe_result;
  logic        pipe_done;

  modport master (
    output req_valid, req_data, pipe_result, pipe_done,
    input  req_ready, resp_valid, resp_data, pipe_start, pipe_dataa
  );

  modport slave (
    input  req_valid, req_data, pipe_result, pipe_done,
    output req_ready, resp_valid, resp_data, pipe_start, pipe_dataa
  );
endinterface

// File: rtl/inner_fn_arbiter.sv
// Round-robin sharing of one pipelined inner-function unit between two requesters.
// Define INNER_FN_ARB_CHECK_EN to add the sticky err output (pipe_done vs tag mismatch).
module inner_fn_arbiter #(
  parameter int unsigned PIPE_LATENCY    = 29,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = 5
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              clk_en,
  inner_fn_arbiter_if.slave bus,
  output logic              busy
`ifdef INNER_FN_ARB_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic {FAV_R0 = 1'b0, FAV_R1 = 1'b1} rr_e;

  rr_e                     ptr_q, ptr_d;
  logic [1:0]              elig;
  logic [1:0]              grant;
  logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [PIPE_LATENCY-1:0] tag_v_q;
  logic [PIPE_LATENCY-1:0] tag_id_q;
  logic                    tag_fire;
  logic [1:0]              resp_valid_q, resp_valid_d;
  logic [31:0]             resp_data_q, resp_data_d;

  // A slot whose result strobes this cycle may be reissued in the same cycle,
  // so a requester sitting at MAX_OUTSTANDING keeps full throughput.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      elig[i] = bus.req_valid[i] & clk_en &
                ((cnt_q[i] < CNT_W'(MAX_OUTSTANDING)) | resp_valid_q[i]);
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ptr_q <= FAV_R0;
    end else if (clk_en) begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0]) begin
      ptr_d = FAV_R1;
    end else if (grant[1]) begin
      ptr_d = FAV_R0;
    end
  end

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = (ptr_q == FAV_R0) ? 2'b01 : 2'b10;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.pipe_start = |grant;
  assign bus.pipe_dataa = grant[1] ? bus.req_data[63:32] : bus.req_data[31:0];

`ifdef INNER_FN_ARB_CHECK_EN
  assign tag_fire = bus.pipe_done & tag_v_q[PIPE_LATENCY-1];
`else
  logic unused_pipe_done;
  assign unused_pipe_done = bus.pipe_done;
  assign tag_fire         = tag_v_q[PIPE_LATENCY-1];
`endif

  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (tag_fire) begin
      resp_valid_d[tag_id_q[PIPE_LATENCY-1]] = 1'b1;
      resp_data_d                            = bus.pipe_result;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      unique case ({grant[i], resp_valid_q[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else if (clk_en) begin
      tag_v_q      <= {tag_v_q[PIPE_LATENCY-2:0], |grant};
      tag_id_q     <= {tag_id_q[PIPE_LATENCY-2:0], grant[1]};
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = (cnt_q[0] != '0) | (cnt_q[1] != '0);

`ifdef INNER_FN_ARB_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q | (bus.pipe_done ^ tag_v_q[PIPE_LATENCY-1]);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      err_q <= 1'b0;
    end else if (clk_en) begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_inner_fn_arbiter.sv
// Randomized bench for inner_fn_arbiter: due-time queue model of issued ops plus directed scenarios.
module tb_inner_fn_arbiter;
  localparam int PL   = 29;
  localparam int MAXO = 8;

  logic clock = 1'b0;
  logic aclr;
  logic clk_en;
  logic busy;
`ifdef INNER_FN_ARB_CHECK_EN
  logic err;
`endif

  inner_fn_arbiter_if bus();

  inner_fn_arbiter #(
    .PIPE_LATENCY(PL),
    .MAX_OUTSTANDING(MAXO),
    .CNT_W(5)
  ) dut (
    .clock(clock),
    .aclr(aclr),
    .clk_en(clk_en),
    .bus(bus),
    .busy(busy)
`ifdef INNER_FN_ARB_CHECK_EN
    ,
    .err(err)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in pipeline: fixed latency, frozen by clk_en, never reset, result = x/2 (exponent - 1).
  logic [PL-1:0] pv;
  logic [31:0]   pd [PL];
  logic          cap_start, cap_en;
  logic [31:0]   cap_data;

  task automatic step();
    @(posedge clock);
    #1;
    if (cap_en) begin
      for (int k = PL - 1; k > 0; k--) begin
        pv[k] = pv[k-1];
        pd[k] = pd[k-1];
      end
      pv[0] = cap_start;
      pd[0] = cap_data - 32'h0080_0000;
    end
    bus.pipe_done   = pv[PL-1];
    bus.pipe_result = pd[PL-1];
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Reference model: every accepted op is an entry due PL+1 enabled cycles after its grant.
  typedef struct {
    int unsigned due;
    bit          id;
    logic [31:0] data;
  } op_t;

  op_t         q[$];
  int unsigned ecount = 0;
  int          m_cnt[2];
  bit          m_ptr;
  logic [31:0] m_rdata;
  bit          m_err;

  always @(negedge clock) begin : cmp
    logic [1:0]  el, eg, er;
    bit          tf;
    logic [31:0] sl;
    if (aclr) begin
      q.delete();
      m_cnt   = '{0, 0};
      m_ptr   = 1'b0;
      m_rdata = '0;
      m_err   = 1'b0;
    end
    er = '0;
    tf = 1'b0;
    foreach (q[j]) begin
      if (q[j].due == ecount)     er[q[j].id] = 1'b1;
      if (q[j].due == ecount + 1) tf = 1'b1;
    end
    for (int i = 0; i < 2; i++)
      el[i] = bus.req_valid[i] && clk_en && (m_cnt[i] < MAXO || er[i]);
    if (el == 2'b11) eg = m_ptr ? 2'b10 : 2'b01;
    else             eg = el;
    sl = eg[1] ? bus.req_data[63:32] : bus.req_data[31:0];

    chk("req_ready", bus.req_ready, eg);
    chk("pipe_start", bus.pipe_start, |eg);
    if (eg != 2'b00) chk("pipe_dataa", bus.pipe_dataa, sl);
    chk("resp_valid", bus.resp_valid, er);
    chk("resp_data", bus.resp_data, m_rdata);
    chk("busy", busy, (m_cnt[0] != 0) || (m_cnt[1] != 0));
`ifdef INNER_FN_ARB_CHECK_EN
    chk("err", err, m_err);
`endif

    cap_start = bus.pipe_start;
    cap_data  = bus.pipe_dataa;
    cap_en    = clk_en;

    if (!aclr && clk_en) begin
      if (bus.pipe_done != tf) m_err = 1'b1;
      for (int i = 0; i < 2; i++) m_cnt[i] += int'(eg[i]) - int'(er[i]);
      if (eg[0])      m_ptr = 1'b1;
      else if (eg[1]) m_ptr = 1'b0;
      for (int j = q.size() - 1; j >= 0; j--)
        if (q[j].due == ecount) q.delete(j);
      if (eg != 2'b00) q.push_back('{ecount + PL + 1, eg[1], sl - 32'h0080_0000});
      ecount++;
      foreach (q[j]) if (q[j].due == ecount) m_rdata = q[j].data;
    end
  end

  task automatic do_reset();
    aclr = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 2'b00);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    step();
    aclr = 1'b0;
  endtask

  initial begin
    int g, g20, nresp, cyc;
    bit found;
    aclr          = 1'b1;
    clk_en        = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    pv            = '0;
    for (int k = 0; k < PL; k++) pd[k] = '0;
    bus.pipe_done   = 1'b0;
    bus.pipe_result = '0;
    cap_start = 1'b0;
    cap_en    = 1'b0;
    cap_data  = '0;
    #1;
    chk("por_busy", busy, 1'b0);
    chk("por_resp_data", bus.resp_data, 32'h0);
    steps(3);
    aclr = 1'b0;

    // single op: 128.0 from requester 0
    steps(9);
    bus.req_valid = 2'b01;
    bus.req_data  = {32'h0, 32'h4300_0000};
    #1;
    chk("single_ready", bus.req_ready, 2'b01);
    chk("single_start", bus.pipe_start, 1'b1);
    for (int k = 1; k <= PL + 1; k++) begin
      step();
      bus.req_valid = '0;
      #1;
      if (k == PL)     chk("single_early", bus.resp_valid, 2'b00);
      if (k == PL + 1) begin
        chk("single_resp", bus.resp_valid, 2'b01);
        chk("single_data", bus.resp_data, 32'h4280_0000);
      end
    end
    step();

    // contention from a fresh pointer
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = 2'b11;
      bus.req_data  = {$urandom, $urandom};
      #1;
      chk("cont_grant", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    bus.req_valid = '0;
    nresp = 0;
    for (int k = 6; k <= 40; k++) begin
      #1;
      if (bus.resp_valid != 2'b00) begin
        if (nresp < 6) begin
          chk("cont_resp_order", bus.resp_valid, (nresp % 2 == 0) ? 2'b01 : 2'b10);
          chk("cont_resp_time", k, PL + 1 + nresp);
        end
        nresp++;
      end
      step();
    end
    chk("cont_resp_count", nresp, 6);

    // credit limit on requester 1
    g = 0;
    g20 = 0;
    for (int k = 0; k < 40; k++) begin
      bus.req_valid = 2'b10;
      bus.req_data  = {$urandom, 32'h0};
      #1;
      if (k == PL)     chk("credit_hold", bus.req_ready[1], 1'b0);
      if (k == PL + 1) chk("credit_reuse", bus.req_ready[1], 1'b1);
      if (k == 38)     chk("credit_full_again", bus.req_ready[1], 1'b0);
      if (bus.req_ready[1]) g++;
      if (k == 19) g20 = g;
      step();
    end
    chk("credit_first20", g20, MAXO);
    chk("credit_total", g, 2 * MAXO);
    bus.req_valid = '0;
    steps(40);
    #1;
    chk("credit_drained", busy, 1'b0);

    // reset with 5 ops in flight; stale pipe_done must not produce responses
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 2'b01;
      bus.req_data  = {32'h0, $urandom};
      step();
    end
    bus.req_valid = '0;
    steps(5);
    #1;
    chk("midflight_busy", busy, 1'b1);
    do_reset();
    steps(PL + 5);
`ifdef INNER_FN_ARB_CHECK_EN
    #1;
    chk("stale_done_err", err, 1'b1);
`endif

    // clk_en stall of 4 cycles mid-flight
    bus.req_valid = 2'b01;
    bus.req_data  = {32'h0, 32'h4000_0000};
    #1;
    chk("stall_issue", bus.req_ready, 2'b01);
    step();
    bus.req_valid = '0;
    steps(9);
    clk_en        = 1'b0;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_ready", bus.req_ready, 2'b00);
      step();
    end
    clk_en        = 1'b1;
    bus.req_valid = '0;
    cyc   = 14;
    found = 1'b0;
    while (cyc <= 45 && !found) begin
      #1;
      if (bus.resp_valid[0]) found = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    chk("stall_latency", cyc, PL + 1 + 4);
    chk("stall_data", bus.resp_data, 32'h3F80_0000);
    step();

    // randomized traffic with occasional clk_en stalls
    for (int k = 0; k < 800; k++) begin
      bus.req_valid = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      bus.req_data  = {$urandom, $urandom};
      clk_en        = ($urandom_range(0, 9) != 0);
      step();
    end
    bus.req_valid = '0;
    clk_en        = 1'b1;
    steps(PL + 12);
    #1;
    chk("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
